mtm_alu_deserializer: RTL and testbench

MTM_ALU_DESERIALIZER -- requirements
Module: mtm_alu_deserializer

---
 rtl/mtm_alu_pkg.sv | 38 +++
 rtl/mtm_alu_uart_rx.sv | 58 +++++
 rtl/mtm_alu_deserializer.sv | 111 +++++++++++
 tb/tb_mtm_alu_deserializer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared types and helpers for the MTM ALU serial request path.
// Holds the operation codes, byte-type and error-index constants, and the CRC4 function.
package mtm_alu_pkg;

    typedef enum logic [2:0] {
        and_op = 3'b000,
        or_op  = 3'b001,
        add_op = 3'b100,
        sub_op = 3'b101
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        RX,
        STOP
    } rx_state_t;

    localparam logic BYTE_DATA = 1'b0;
    localparam logic BYTE_CMD  = 1'b1;

    localparam int unsigned ERR_W        = 3;
    localparam int unsigned ERR_DATA_IDX = 2;
    localparam int unsigned ERR_CRC_IDX  = 1;
    localparam int unsigned ERR_OP_IDX   = 0;

    // x^4+x+1, zero init, data consumed MSB first
    function automatic logic [3:0] crc4(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = '0;
        for (int unsigned i = 68; i > 0; i--) begin
            fb = c[3] ^ d[i-1];
            c  = {c[2:0], 1'b0} ^ ({4{fb}} & 4'b0011);
        end
        return c;
    endfunction

endpackage

// File: rtl/mtm_alu_uart_rx.sv
// Serial byte receiver: start bit, type bit, 8 payload bits MSB first, stop bit.
// byte_valid / frame_err are asserted combinationally in the cycle the stop bit is sampled.
module mtm_alu_uart_rx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sin,
    output logic       byte_valid,
    output logic       is_cmd,
    output logic [7:0] payload,
    output logic       frame_err
);

    rx_state_t  r_state;
    rx_state_t  w_next;
    logic [3:0] r_bit_cnt;
    logic [8:0] r_shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!sin) w_next = RX;
            RX:      if (r_bit_cnt == 4'd8) w_next = STOP;
            STOP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Nine samples in RX: the type bit followed by the eight payload bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (r_state == RX) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_shift   <= {r_shift[7:0], sin};
        end else begin
            r_bit_cnt <= '0;
        end
    end

    always_comb begin
        byte_valid = (r_state == STOP) && sin;
        frame_err  = (r_state == STOP) && !sin;
        is_cmd     = r_shift[8];
        payload    = r_shift[7:0];
    end

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Packet assembly for the MTM ALU: eight data bytes form {B,A}, a CMD byte closes the packet.
// Outputs and error flags are registered and change only alongside the out_valid pulse.
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
#(
    parameter logic CHECK_CRC = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  op,
    output logic [3:0]  crc_rx,
    output logic        err_data,
    output logic        err_crc,
    output logic        err_op
);

    logic             w_byte_valid;
    logic             w_is_cmd;
    logic [7:0]       w_payload;
    logic             w_frame_err;
    logic [3:0]       w_crc_exp;
    logic             w_op_legal;
    logic [ERR_W-1:0] w_err;

    logic [3:0]       r_cnt;
    logic [63:0]      r_shift;
    logic             r_valid;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [2:0]       r_op;
    logic [3:0]       r_crc;
    logic [ERR_W-1:0] r_err;

    mtm_alu_uart_rx u_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .sin        (sin),
        .byte_valid (w_byte_valid),
        .is_cmd     (w_is_cmd),
        .payload    (w_payload),
        .frame_err  (w_frame_err)
    );

    assign w_crc_exp = crc4({r_shift, 1'b1, w_payload[6:4]});

    always_comb begin
        case (operation_t'(w_payload[6:4]))
            and_op, or_op, add_op, sub_op: w_op_legal = 1'b1;
            default:                       w_op_legal = 1'b0;
        endcase
    end

    // Priority chain guarantees at most one flag per packet.
    always_comb begin
        w_err = '0;
        if (r_cnt != 4'd8) begin
            w_err[ERR_DATA_IDX] = 1'b1;
        end else if (CHECK_CRC && (w_payload[3:0] != w_crc_exp)) begin
            w_err[ERR_CRC_IDX] = 1'b1;
        end else if (!w_op_legal) begin
            w_err[ERR_OP_IDX] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_crc   <= '0;
            r_err   <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_frame_err) begin
                r_cnt <= '0;
            end else if (w_byte_valid) begin
                if (w_is_cmd == BYTE_CMD) begin
                    r_valid <= 1'b1;
                    r_b     <= r_shift[63:32];
                    r_a     <= r_shift[31:0];
                    r_op    <= w_payload[6:4];
                    r_crc   <= w_payload[3:0];
                    r_err   <= w_err;
                    r_cnt   <= '0;
                end else begin
                    r_shift <= {r_shift[55:0], w_payload};
                    if (r_cnt != 4'd9) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign A         = r_a;
    assign B         = r_b;
    assign op        = r_op;
    assign crc_rx    = r_crc;
    assign err_data  = r_err[ERR_DATA_IDX];
    assign err_crc   = r_err[ERR_CRC_IDX];
    assign err_op    = r_err[ERR_OP_IDX];

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Scoreboard bench for mtm_alu_deserializer: packet-level reference model feeds an expected
// queue; a negedge monitor pops on every out_valid and checks hold behaviour in between.
module tb_mtm_alu_deserializer;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [3:0]  crc;
        logic        ed;
        logic        ec;
        logic        eo;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        sin;
    logic        out_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  op;
    logic [3:0]  crc_rx;
    logic        err_data;
    logic        err_crc;
    logic        err_op;

    int   errors   = 0;
    int   checks   = 0;
    int   n_pushed = 0;
    int   n_seen   = 0;
    int   n_data   = 0;
    exp_t sb[$];
    exp_t last;
    logic [7:0] data_q[$];

    mtm_alu_deserializer #(.CHECK_CRC(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sin       (sin),
        .out_valid (out_valid),
        .A         (A),
        .B         (B),
        .op        (op),
        .crc_rx    (crc_rx),
        .err_data  (err_data),
        .err_crc   (err_crc),
        .err_op    (err_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Remainder of ({B,A,1,op} * x^4) divided by x^4+x+1.
    function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] o);
        logic [71:0] v;
        v = {b, a, 1'b1, o, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
        return v[3:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (out_valid) begin
                n_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got out_valid=1, required 0 (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("op", {61'd0, op}, {61'd0, e.op});
                    check("crc_rx", {60'd0, crc_rx}, {60'd0, e.crc});
                    check("flags", {61'd0, err_data, err_crc, err_op}, {61'd0, e.ed, e.ec, e.eo});
                    if (!e.ed) check("BA", {B, A}, {e.b, e.a});
                    last = e;
                end
            end else begin
                check("hold", {61'd0, op, crc_rx, err_data, err_crc, err_op},
                      {61'd0, last.op, last.crc, last.ed, last.ec, last.eo});
                if (!last.ed) check("hold_BA", {B, A}, {last.b, last.a});
            end
        end
    end

    task automatic send_bit(input logic b);
        sin = b;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic typ, input logic [7:0] pl, input logic stop);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(pl[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic data_byte(input logic [7:0] pl, input logic stop);
        send_byte(1'b0, pl, stop);
        if (stop) begin
            data_q.push_back(pl);
            if (data_q.size() > 8) void'(data_q.pop_front());
            n_data++;
        end else begin
            data_q.delete();
            n_data = 0;
        end
    endtask

    task automatic cmd_byte(input logic [2:0] o, input logic [3:0] c);
        exp_t e;
        e     = '0;
        e.op  = o;
        e.crc = c;
        e.ed  = (n_data != 8);
        if (n_data == 8) begin
            e.b  = {data_q[0], data_q[1], data_q[2], data_q[3]};
            e.a  = {data_q[4], data_q[5], data_q[6], data_q[7]};
            e.ec = (c != ref_crc(e.b, e.a, o));
            e.eo = !e.ec && !(o inside {3'b000, 3'b001, 3'b100, 3'b101});
        end
        sb.push_back(e);
        n_pushed++;
        send_byte(1'b1, {1'b0, o, c}, 1'b1);
        check("latency", {63'd0, out_valid}, 64'd1);
        data_q.delete();
        n_data = 0;
    endtask

    task automatic packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] o,
                          input logic [3:0] crc_xor);
        logic [63:0] ba;
        ba = {b, a};
        for (int i = 7; i >= 0; i--) data_byte(ba[i*8 +: 8], 1'b1);
        cmd_byte(o, ref_crc(b, a, o) ^ crc_xor);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sin     = 1'b1;
        @(negedge clk);
        check("rst_outputs", {out_valid, A, B[26:0], op, crc_rx, err_data, err_crc, err_op},
              64'd0);
        check("rst_B", {32'd0, B}, 64'd0);
        @(negedge clk);
        last = '0;
        data_q.delete();
        n_data  = 0;
        reset_n = 1'b1;
    endtask

    initial begin
        int          n;
        logic [2:0]  o;
        logic [3:0]  x;
        last    = '0;
        reset_n = 1'b0;
        sin     = 1'b1;
        do_reset();
        idle(2);

        // directed 1, followed back-to-back by a second packet
        packet(32'h1, 32'h2, 3'b100, 4'h0);
        packet(32'hDEAD_BEEF, 32'h1234_5678, 3'b101, 4'h0);
        idle(1);

        // directed 2: short packet, then a clean one
        for (int i = 0; i < 7; i++) data_byte(8'(8'h10 + i), 1'b1);
        cmd_byte(3'b000, 4'h5);
        packet(32'hCAFE_0001, 32'h0000_00FF, 3'b001, 4'h0);
        idle(3);

        // directed 3 and 4
        packet(32'hFFFF_FFFF, 32'h1, 3'b100, 4'b0001);
        packet(32'h5, 32'h3, 3'b010, 4'h0);
        idle(2);

        // directed 5: reset mid-packet
        for (int i = 0; i < 3; i++) data_byte(8'hA0, 1'b1);
        do_reset();
        packet(32'h7, 32'h9, 3'b000, 4'h0);
        idle(2);

        // directed 6: stop bit 0 in data byte 4
        for (int i = 0; i < 3; i++) data_byte(8'h3C, 1'b1);
        data_byte(8'h3C, 1'b0);
        idle(2);
        packet(32'h0102_0304, 32'h0506_0708, 3'b101, 4'h0);

        // long packet: last 8 data bytes survive but the count saturates -> err_data
        for (int i = 0; i < 10; i++) data_byte(8'(i), 1'b1);
        cmd_byte(3'b100, 4'h0);

        // random packets with random gaps
        for (int k = 0; k < 40; k++) begin
            o = 3'($urandom_range(0, 7));
            x = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 3) != 0) begin
                packet($urandom, $urandom, o, x);
            end else begin
                n = $urandom_range(5, 10);
                for (int i = 0; i < n; i++) data_byte(8'($urandom), 1'b1);
                cmd_byte(o, x);
            end
            idle($urandom_range(0, 2));
        end

        idle(6);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("valid_count", 64'(n_seen), 64'(n_pushed));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
